// File: rtl/exec_pkg.sv
// Shared definitions for the execution controller: opcodes, FSM states,
// instruction field positions and a decode helper.
package exec_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int INSTR_W    = 16;
    localparam int REG_IDX_W  = 3;
    localparam int IMM_W      = 8;

    // Instruction field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_MOV = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        opcode_e              op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [IMM_W-1:0]     imm;
    } instr_t;

    // Split a raw instruction word into its fields (imm8 overlaps rs1/rs2).
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op  = opcode_e'(w[OP_MSB:OP_LSB]);
        d.rd  = w[RD_MSB:RD_LSB];
        d.rs1 = w[RS1_MSB:RS1_LSB];
        d.rs2 = w[RS2_MSB:RS2_LSB];
        d.imm = w[IMM_MSB:IMM_LSB];
        return d;
    endfunction

    // Only the arithmetic/logic opcodes update ZERO/CARRY.
    function automatic logic op_sets_flags(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/exec_if.sv
// Instruction handshake, register-file ports and status flags of the controller.
interface exec_if import exec_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic               INSTR_VALID;
    logic [INSTR_W-1:0] INSTR;
    logic               INSTR_READY;
    logic [ADDR_W-1:0]  READ_REG1;
    logic [ADDR_W-1:0]  READ_REG2;
    logic [DATA_W-1:0]  DATA1;
    logic [DATA_W-1:0]  DATA2;
    logic [ADDR_W-1:0]  WRITE_REG;
    logic [DATA_W-1:0]  WRITE_DATA;
    logic               REG_WRITE;
    logic               ZERO_FLAG;
    logic               CARRY_FLAG;
    logic               BUSY;

    // Controller side
    modport master (
        input  INSTR_VALID, INSTR, DATA1, DATA2,
        output INSTR_READY, READ_REG1, READ_REG2, WRITE_REG, WRITE_DATA,
               REG_WRITE, ZERO_FLAG, CARRY_FLAG, BUSY
    );

    // Instruction source / register file side
    modport slave (
        output INSTR_VALID, INSTR, DATA1, DATA2,
        input  INSTR_READY, READ_REG1, READ_REG2, WRITE_REG, WRITE_DATA,
               REG_WRITE, ZERO_FLAG, CARRY_FLAG, BUSY
    );

endinterface

// File: rtl/alu8.sv
// Purely combinational 8-bit ALU: result plus zero/carry for every opcode.
module alu8 import exec_pkg::*; (
    input  opcode_e    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry
);

    logic [8:0] sum9;
    logic [8:0] diff9;

    // Opcode decode into result/carry; bit 8 of the 9-bit difference is the borrow
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        result = '0;
        carry  = 1'b0;
        sum9   = {1'b0, a} + {1'b0, b};
        diff9  = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD: begin result = sum9[7:0];  carry = sum9[8];  end
            OP_SUB: begin result = diff9[7:0]; carry = diff9[8]; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_LDI: result = b;
            OP_MOV: result = a;
            default: result = '0;
        endcase
        zero = (result == 8'd0);
    end

endmodule

// File: rtl/exec_controller.sv
// Four-state instruction executor: fetch handshake, operand read, ALU, write-back.
module exec_controller import exec_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic  CLK,
    input  logic  RST_N,
    exec_if.master bus
);

    state_e            state;
    state_e            state_nxt;
    logic [INSTR_W-1:0] ir;
    instr_t            dec;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] write_reg;
    logic              reg_write;
    logic              zero_flag;
    logic              carry_flag;

    // Field view of the latched instruction; LDI routes imm8 into the ALU b input
    always_comb begin
        dec   = decode_instr(ir);
        alu_b = (dec.op == OP_LDI) ? dec.imm : op_b;
    end

    alu8 u_alu (
        .op     (dec.op),
        .a      (op_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: wait in IDLE for a valid instruction, then a fixed 4-cycle walk
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bus.INSTR_VALID) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers: IR in IDLE, operands in READ, result/flags/write strobe in EXEC
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            write_reg  <= '0;
            reg_write  <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse covering the WB state only
            reg_write <= 1'b0;
            case (state)
                ST_IDLE: if (bus.INSTR_VALID) ir <= bus.INSTR;
                ST_READ: begin
                    op_a <= bus.DATA1;
                    op_b <= bus.DATA2;
                end
                ST_EXEC: begin
                    result    <= alu_result;
                    write_reg <= dec.rd;
                    reg_write <= (dec.op != OP_NOP);
                    if (op_sets_flags(dec.op)) begin
                        zero_flag  <= alu_zero;
                        carry_flag <= alu_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: handshake/status from the state, everything else straight from registers
    always_comb begin
        bus.INSTR_READY = (state == ST_IDLE);
        bus.BUSY        = (state != ST_IDLE);
        bus.READ_REG1   = dec.rs1;
        bus.READ_REG2   = dec.rs2;
        bus.WRITE_REG   = write_reg;
        bus.WRITE_DATA  = result;
        bus.REG_WRITE   = reg_write;
        bus.ZERO_FLAG   = zero_flag;
        bus.CARRY_FLAG  = carry_flag;
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a cycle-level timeline model and register file.
module tb_exec_controller;

    logic CLK = 1'b0;
    logic RST_N;

    exec_if bus ();

    exec_controller dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Environment register file: asynchronous read, written on REG_WRITE
    logic [7:0] rf [8] = '{default: 8'h00};
    always @(posedge CLK) if (bus.REG_WRITE === 1'b1) rf[bus.WRITE_REG] <= bus.WRITE_DATA;
    assign bus.DATA1 = rf[bus.READ_REG1];
    assign bus.DATA2 = rf[bus.READ_REG2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model: an instruction accepted at the edge that opens cycle c
    // writes back in cycle c+2 and the block is ready again in cycle c+3.
    // ------------------------------------------------------------------
    int   m_rf [8] = '{default: 0};
    int   m_ready_at = 0;
    int   m_z = 0, m_c = 0, m_rs1 = 0, m_rs2 = 0;
    bit   m_on = 0, rst_edge = 0, acc_edge = 0;
    logic [15:0] acc_word;
    bit   p_valid = 0, p_write = 0, p_flags = 0;
    int   p_wb, p_rd, p_data, p_z, p_c;
    int   m_op, m_a, m_b;
    bit   wb_now;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            // effects of the edge that opened this cycle
            if (rst_edge) begin
                m_on = 1; p_valid = 0; m_ready_at = cyc;
                m_z = 0; m_c = 0; m_rs1 = 0; m_rs2 = 0;
            end else if (acc_edge) begin
                m_op  = int'(acc_word[15:13]);
                p_rd  = int'(acc_word[12:10]);
                m_rs1 = int'(acc_word[9:7]);
                m_rs2 = int'(acc_word[6:4]);
                m_a   = m_rf[m_rs1];
                m_b   = m_rf[m_rs2];
                p_valid = 1; p_wb = cyc + 2; m_ready_at = cyc + 3;
                p_write = (m_op != 0);
                p_flags = (m_op >= 1 && m_op <= 5);
                p_c = 0;
                case (m_op)
                    1: begin p_data = (m_a + m_b) % 256; p_c = (m_a + m_b > 255) ? 1 : 0; end
                    2: begin p_data = (m_a - m_b + 256) % 256; p_c = (m_a < m_b) ? 1 : 0; end
                    3: p_data = m_a & m_b;
                    4: p_data = m_a | m_b;
                    5: p_data = m_a ^ m_b;
                    6: p_data = int'(acc_word[7:0]);
                    7: p_data = m_a;
                    default: p_data = 0;
                endcase
                p_z = (p_data == 0) ? 1 : 0;
            end
            wb_now = p_valid && (cyc == p_wb);
            if (wb_now && p_flags) begin m_z = p_z; m_c = p_c; end

            if (m_on) begin
                check("ready",     bus.INSTR_READY, cyc >= m_ready_at);
                check("busy",      bus.BUSY,        cyc <  m_ready_at);
                check("reg_write", bus.REG_WRITE,   wb_now && p_write);
                if (wb_now && p_write) begin
                    check("write_reg",  bus.WRITE_REG,  p_rd);
                    check("write_data", bus.WRITE_DATA, p_data);
                end
                check("read_reg1",  bus.READ_REG1,  m_rs1);
                check("read_reg2",  bus.READ_REG2,  m_rs2);
                check("zero_flag",  bus.ZERO_FLAG,  m_z);
                check("carry_flag", bus.CARRY_FLAG, m_c);
            end

            if (wb_now) begin
                if (p_write) m_rf[p_rd] = p_data;
                p_valid = 0;
            end
            // inputs that the next edge will sample
            rst_edge = (RST_N === 1'b0);
            acc_edge = !rst_edge && m_on && (bus.INSTR_VALID === 1'b1) && (cyc >= m_ready_at);
            acc_word = bus.INSTR;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        logic [2:0] o, d, s1, s2;
        o = op[2:0]; d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
        return {o, d, s1, s2, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_i(input int rd, input int imm);
        logic [2:0] d;
        logic [7:0] v;
        d = rd[2:0]; v = imm[7:0];
        return {3'b110, d, 2'b00, v};
    endfunction

    // Present w until accepted; returns 2 time units after the accepting edge
    task automatic issue(input logic [15:0] w, input bit hold);
        int waited;
        waited = 0;
        @(posedge CLK); #2;
        bus.INSTR = w;
        bus.INSTR_VALID = 1'b1;
        do begin
            @(negedge CLK);
            waited++;
        end while (bus.INSTR_READY !== 1'b1 && waited < 20);
        check("accept_ready", bus.INSTR_READY, 1);
        @(posedge CLK); #2;
        bus.INSTR = 16'($urandom);
        if (!hold) bus.INSTR_VALID = 1'b0;
    endtask

    // Wait (bounded) for the write strobe and compare against literal values
    task automatic expect_write(input string name, input int rd, input int data, input int z, input int c);
        int n;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (bus.REG_WRITE === 1'b1) begin n = i; break; end
        end
        check({name, "_latency"}, n, 3);
        if (n != 0) begin
            check({name, "_rd"},    bus.WRITE_REG,  rd);
            check({name, "_data"},  bus.WRITE_DATA, data);
            check({name, "_zero"},  bus.ZERO_FLAG,  z);
            check({name, "_carry"}, bus.CARRY_FLAG, c);
        end
    endtask

    task automatic ldi(input int rd, input int imm, input int z, input int c);
        issue(enc_i(rd, imm), 1'b0);
        expect_write("ldi", rd, imm, z, c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        RST_N = 1'b0;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = '0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_ready",     bus.INSTR_READY, 1);
        check("rst_reg_write", bus.REG_WRITE,   0);
        check("rst_flags",     {bus.ZERO_FLAG, bus.CARRY_FLAG}, 0);
        check("rst_read_regs", {bus.READ_REG1, bus.READ_REG2}, 0);

        // ADD with carry-out: 200 + 100 = 300 -> 44
        ldi(1, 200, 0, 0);
        ldi(2, 100, 0, 0);
        issue(enc_r(1, 3, 1, 2), 1'b0);
        expect_write("add_wrap", 3, 44, 0, 1);
        // LDI / MOV leave flags alone
        issue(enc_i(7, 'hA5), 1'b0);
        expect_write("ldi_flags", 7, 'hA5, 0, 1);
        issue(enc_r(7, 5, 3, 0), 1'b0);
        expect_write("mov", 5, 44, 0, 1);
        // SUB equal -> zero, then borrow
        ldi(1, 5, 0, 1);
        ldi(2, 5, 0, 1);
        issue(enc_r(2, 4, 1, 2), 1'b0);
        expect_write("sub_zero", 4, 0, 1, 0);
        ldi(1, 3, 1, 0);
        issue(enc_r(2, 4, 1, 2), 1'b0);
        expect_write("sub_borrow", 4, 254, 0, 1);
        // Logic ops clear carry
        ldi(1, 'hF0, 0, 1);
        ldi(2, 'h3C, 0, 1);
        issue(enc_r(3, 6, 1, 2), 1'b0);
        expect_write("and", 6, 'h30, 0, 0);
        issue(enc_r(4, 6, 1, 2), 1'b0);
        expect_write("or", 6, 'hFC, 0, 0);
        issue(enc_r(5, 6, 1, 2), 1'b0);
        expect_write("xor", 6, 'hCC, 0, 0);
        // rd == rs1 == rs2
        issue(enc_r(5, 1, 1, 1), 1'b0);
        expect_write("xor_self", 1, 0, 1, 0);
        // ADD wrapping to zero sets both flags
        ldi(1, 255, 1, 0);
        ldi(2, 1, 1, 0);
        issue(enc_r(1, 0, 1, 2), 1'b0);
        expect_write("add_to_zero", 0, 0, 1, 1);

        // NOP: no write, ready again after exactly 4 cycles
        issue(enc_r(0, 3, 1, 2), 1'b0);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            check("nop_no_write", bus.REG_WRITE, 0);
            if (bus.INSTR_READY === 1'b1) begin n = i; break; end
        end
        check("nop_ready_latency", n, 4);
        check("nop_flags", {bus.ZERO_FLAG, bus.CARRY_FLAG}, 2'b11);

        // Back-to-back with INSTR_VALID held high and junk on INSTR while busy
        issue(enc_r(2, 3, 1, 2), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            check("b2b_ready", bus.INSTR_READY, (i == 4));
            if (i == 3) begin
                check("b2b_first_we",   bus.REG_WRITE,  1);
                check("b2b_first_data", bus.WRITE_DATA, 254);
            end
            @(posedge CLK); #2;
            if (i == 3)      bus.INSTR = enc_i(5, 'h5A);
            else if (i == 4) begin bus.INSTR_VALID = 1'b0; bus.INSTR = 16'($urandom); end
            else             bus.INSTR = 16'($urandom);
        end
        expect_write("b2b_second", 5, 'h5A, 0, 0);

        // Reset while in EXEC aborts the write
        issue(enc_i(6, 'h77), 1'b0);
        @(posedge CLK); #2 RST_N = 1'b0;
        @(posedge CLK); #2 RST_N = 1'b1;
        @(negedge CLK);
        check("abort_ready",      bus.INSTR_READY, 1);
        check("abort_busy",       bus.BUSY,        0);
        check("abort_reg_write",  bus.REG_WRITE,   0);
        check("abort_write_reg",  bus.WRITE_REG,   0);
        check("abort_write_data", bus.WRITE_DATA,  0);
        check("abort_flags",      {bus.ZERO_FLAG, bus.CARRY_FLAG}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abort_no_write", bus.REG_WRITE, 0);
        end
        // r6 must still hold its pre-abort value
        issue(enc_r(7, 2, 6, 0), 1'b0);
        expect_write("mov_after_abort", 2, 'hCC, 0, 0);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register and ALU data width; only 8 is supported.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning register index width (8 registers).
REQ-003 The block SHALL have port CLK  input  1  meaning the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port INSTR_VALID  input  1  meaning the upstream instruction is valid.
REQ-006 The block SHALL have port INSTR  input  16  meaning the instruction word: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm8.
REQ-007 The block SHALL have port INSTR_READY  output  1  meaning the block accepts an instruction this cycle.
REQ-008 The block SHALL have ports READ_REG1 and READ_REG2  output  3 each  meaning the register-file read indices.
REQ-009 The block SHALL have ports DATA1 and DATA2  input  8 each  meaning the asynchronous register-file read data.
REQ-010 The block SHALL have ports WRITE_REG  output  3, WRITE_DATA  output  8 and REG_WRITE  output  1  meaning the register-file write port.
REQ-011 The block SHALL have ports ZERO_FLAG and CARRY_FLAG  output  1 each  meaning the flags of the last ALU operation.
REQ-012 The block SHALL have port BUSY  output  1  meaning the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, READ, EXEC and WB.
REQ-014 INSTR_READY SHALL be 1 only in IDLE, and an instruction SHALL be accepted when INSTR_VALID and INSTR_READY are both 1 at a rising edge.
REQ-015 On acceptance the FSM SHALL latch INSTR into an internal IR and move IDLE->READ; with INSTR_VALID=0 it SHALL stay in IDLE.
REQ-016 In READ the block SHALL drive READ_REG1=IR.rs1 and READ_REG2=IR.rs2, register DATA1/DATA2 into operand registers at the edge, and move to EXEC.
REQ-017 In EXEC the block SHALL register the result, and flags where they apply, and move to WB.
REQ-018 Opcodes SHALL be: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LDI (rd<=imm8), 111 MOV (rd<=rs1).
REQ-019 ADD SHALL produce an 8-bit result that wraps modulo 256, with CARRY = bit 8 of the 9-bit sum.
REQ-020 SUB SHALL produce an 8-bit result that wraps modulo 256, with CARRY = borrow (rs1 < rs2, unsigned).
REQ-021 AND, OR and XOR SHALL clear CARRY.
REQ-022 ZERO SHALL be 1 when the 8-bit ALU result is 0.
REQ-023 Flags SHALL update only for ADD/SUB/AND/OR/XOR; NOP, LDI and MOV SHALL leave ZERO_FLAG and CARRY_FLAG unchanged.
REQ-024 In WB, REG_WRITE SHALL be 1 for exactly one cycle with WRITE_REG=IR.rd and WRITE_DATA=result, except for NOP (REG_WRITE=0); the FSM SHALL then return to IDLE.
REQ-025 Latency SHALL be fixed for every opcode, NOP included: acceptance at edge N -> REG_WRITE high in the cycle after edge N+2 -> INSTR_READY high again after edge N+3.
REQ-026 The back-to-back acceptance rate SHALL be one instruction per 4 cycles.
REQ-027 rd equal to rs1 or rs2 SHALL be legal: operands are captured in READ, before the write.
REQ-028 INSTR changes while BUSY=1 SHALL have no effect.
REQ-029 READ_REG1/READ_REG2 SHALL hold the IR indices in all states and 0 after reset.
REQ-030 WRITE_REG, WRITE_DATA, REG_WRITE and the flags SHALL be driven from registers.

Reset
REQ-031 When RST_N=0 at a rising edge, the FSM SHALL go to IDLE, and IR, operands, result, WRITE_REG, WRITE_DATA, REG_WRITE, ZERO_FLAG and CARRY_FLAG SHALL all be 0.
REQ-032 A reset in any state SHALL abort the instruction in flight without a register-file write; REG_WRITE SHALL be 0 from the reset edge onward.
REQ-033 INSTR_READY SHALL be 1 in the first cycle after reset is released.

Structure
REQ-034 A shared package exec_pkg SHALL hold the opcode constants, the FSM state encoding and the instruction-field bit positions.
REQ-035 A combinational sub-module alu8 SHALL take op, a and b, and return result, zero and carry.
REQ-036 exec_controller SHALL instantiate alu8 once.

Verification
REQ-037 Scenario: preload r1=200, r2=100; send ADD rd=3 rs1=1 rs2=2 -> REG_WRITE in the 3rd cycle after acceptance, WRITE_REG=3, WRITE_DATA=44, CARRY=1, ZERO=0.
REQ-038 Scenario: SUB rd=4 with r1=5, r2=5 -> WRITE_DATA=0, ZERO=1, CARRY=0; then r1=3, r2=5 -> WRITE_DATA=254, CARRY=1.
REQ-039 Scenario: LDI rd=7 imm=0xA5 after an ADD that set the flags -> WRITE_DATA=0xA5, flags unchanged.
REQ-040 Scenario: NOP -> REG_WRITE stays 0; INSTR_READY returns after exactly 4 cycles.
REQ-041 Scenario: INSTR_VALID held high with two queued instructions -> accepted 4 cycles apart; INSTR ignored while BUSY.
REQ-042 Scenario: assert RST_N=0 while in EXEC -> no write occurs, all outputs 0, INSTR_READY=1 one cycle after release.
